fsm_tx: RTL and testbench

- Transmit end of the single-wire pulse protocol decoded by the existing receive FSM.
- Emits single-clock pulses ("edges") on DATA_OUT in this order:
  - 3-pulse sync preamble.
  - Metadata start pulse.
  - 4 duration-encoded metadata bits.
  - Scan start pulse.
  - A programmable number of alternating pos/neg scan half-period pulses.
- Sits on the controller side and drives the receiver's DATA_IN.

---
 rtl/fsm_pkg.sv | 29 ++
 rtl/fsm_tx_interval.sv | 58 +++++
 rtl/fsm_tx.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fsm_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// -----------------------------------------------------------------------------
// fsm_pkg
// Shared definitions for the single-wire pulse protocol (transmit and receive).
//   fsm_state_t   : state encoding, also decoded by the receiver's debug LEDs
//   NUM_SYNC      : pulses in the sync preamble
//   NUM_META_BITS : duration-encoded metadata bits per frame
//   fsm_max()     : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package fsm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SYNC       = 4'd1,
        ST_META_START = 4'd2,
        ST_BIT_A      = 4'd3,
        ST_BIT_B      = 4'd4,
        ST_SCAN_START = 4'd5,
        ST_SCAN       = 4'd6,
        ST_DONE       = 4'd7
    } fsm_state_t;

    localparam int NUM_SYNC      = 3;
    localparam int NUM_META_BITS = 4;

    function automatic int fsm_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fsm_tx_interval.sv
// -----------------------------------------------------------------------------
// fsm_tx_interval
// Loadable down-counter that raises o_expire for one cycle exactly
// i_ticks*CLKS_PER_TICK clocks after the load edge. One instance is reused for
// every gap in the frame.
//   CLK_IN   : clock
//   rst_n    : asynchronous active-low reset
//   i_clear  : stop counting (priority over load)
//   i_load   : start a new interval of i_ticks ticks (restarts a running one)
//   i_ticks  : interval length in ticks, must be >= 1
//   o_expire : one-cycle strobe in the last clock of the interval
// -----------------------------------------------------------------------------
module fsm_tx_interval
    import fsm_pkg::*;
#(
    parameter int CLKS_PER_TICK = 1000,
    parameter int MAX_TICKS     = 3,
    localparam int TW = $clog2(MAX_TICKS + 1),
    localparam int CW = $clog2(MAX_TICKS * CLKS_PER_TICK + 1)
) (
    input  logic          CLK_IN,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [TW-1:0] i_ticks,
    output logic          o_expire
);

    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic [CW-1:0] w_load_val;

    // Loading N-1 makes the strobe land in the cycle before the next pulse
    // edge, so consecutive pulse-high cycles are exactly N clocks apart.
    assign w_load_val = CW'(i_ticks) * CW'(CLKS_PER_TICK) - CW'(1);

    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= w_load_val;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign o_expire = r_run && (r_cnt == '0);

endmodule

// File: rtl/fsm_tx.sv
// -----------------------------------------------------------------------------
// fsm_tx
// Transmit side of the single-wire pulse protocol. A frame is:
//   3 sync pulses, metadata start pulse, 4 duration-coded bits (2 pulses each,
//   LSB first), scan start pulse, then scan_halves alternating scan pulses.
// Every pulse is one CLK_IN cycle high; gaps are counted from pulse to pulse.
//   CLK_IN      : system clock
//   rst_n       : asynchronous active-low reset
//   start       : frame request, accepted only in IDLE (abort wins over it)
//   meta        : metadata nibble, latched when start is accepted
//   scan_halves : scan pulse count, latched when start is accepted
//   abort       : drop the current frame on the next edge, no done strobe
//   DATA_OUT    : pulse line to the receiver
//   busy        : frame in progress (first pulse through last pulse)
//   done        : one-cycle strobe the cycle after the last pulse
//   phase       : 0 = SendPos, 1 = SendNeg, as the receiver tracks it
//   state_dbg   : current state encoding
// -----------------------------------------------------------------------------
module fsm_tx
    import fsm_pkg::*;
#(
    parameter int CLKS_PER_TICK = 1000,
    parameter int SYNC_GAP      = 2,
    parameter int META_GAP      = 3,
    parameter int SHORT_T       = 1,
    parameter int LONG_T        = 3,
    parameter int SCAN_HALF     = 2
) (
    input  logic       CLK_IN,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] meta,
    input  logic [7:0] scan_halves,
    input  logic       abort,
    output logic       DATA_OUT,
    output logic       busy,
    output logic       done,
    output logic       phase,
    output logic [3:0] state_dbg
);

    localparam int MAX_TICKS = fsm_max(fsm_max(SYNC_GAP, META_GAP),
                                       fsm_max(LONG_T, SCAN_HALF));
    localparam int TW = $clog2(MAX_TICKS + 1);

    fsm_state_t r_state;
    logic       r_data_out;
    logic       r_busy;
    logic       r_done;
    logic       r_phase;
    logic       r_fin;          // last pulse sent, DONE follows next edge
    logic [3:0] r_meta;
    logic [7:0] r_scan_halves;
    logic [7:0] r_scan_cnt;
    logic [1:0] r_sync_cnt;
    logic [1:0] r_bit_idx;

    logic          w_abort;
    logic          w_expire;
    logic          w_pulse;
    logic          w_load;
    logic [TW-1:0] w_ticks;
    logic [1:0]    w_bit_next;
    logic [7:0]    w_scan_next;

    assign w_abort     = abort && (r_state != ST_IDLE);
    assign w_bit_next  = r_bit_idx + 2'd1;
    assign w_scan_next = r_scan_cnt + 8'd1;

    // Pulse and next-gap decode. A pulse always restarts the interval with
    // the gap to the following pulse; the final pulse loads nothing.
    always_comb begin
        w_pulse = 1'b0;
        w_load  = 1'b0;
        w_ticks = '0;
        if (!w_abort) begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        w_pulse = 1'b1;
                        w_load  = 1'b1;
                        w_ticks = TW'(SYNC_GAP);
                    end
                end
                ST_SYNC: begin
                    if (w_expire) begin
                        w_pulse = 1'b1;
                        w_load  = 1'b1;
                        w_ticks = (r_sync_cnt == 2'(NUM_SYNC - 1)) ? TW'(META_GAP)
                                                                  : TW'(SYNC_GAP);
                    end
                end
                ST_META_START: begin
                    if (w_expire) begin
                        w_pulse = 1'b1;
                        w_load  = 1'b1;
                        w_ticks = r_meta[0] ? TW'(LONG_T) : TW'(SHORT_T);
                    end
                end
                ST_BIT_A: begin
                    if (w_expire) begin
                        w_pulse = 1'b1;
                        w_load  = 1'b1;
                        w_ticks = r_meta[r_bit_idx] ? TW'(SHORT_T) : TW'(LONG_T);
                    end
                end
                ST_BIT_B: begin
                    if (w_expire) begin
                        w_pulse = 1'b1;
                        w_load  = 1'b1;
                        if (r_bit_idx == 2'(NUM_META_BITS - 1)) begin
                            w_ticks = TW'(META_GAP);
                        end else begin
                            w_ticks = r_meta[w_bit_next] ? TW'(LONG_T) : TW'(SHORT_T);
                        end
                    end
                end
                ST_SCAN_START: begin
                    if (w_expire) begin
                        w_pulse = 1'b1;
                        w_load  = (r_scan_halves != 8'd0);
                        w_ticks = TW'(SCAN_HALF);
                    end
                end
                ST_SCAN: begin
                    if (w_expire) begin
                        w_pulse = 1'b1;
                        w_load  = (w_scan_next != r_scan_halves);
                        w_ticks = TW'(SCAN_HALF);
                    end
                end
                default: ;
            endcase
        end
    end

    fsm_tx_interval #(
        .CLKS_PER_TICK (CLKS_PER_TICK),
        .MAX_TICKS     (MAX_TICKS)
    ) u_interval (
        .CLK_IN   (CLK_IN),
        .rst_n    (rst_n),
        .i_clear  (w_abort),
        .i_load   (w_load),
        .i_ticks  (w_ticks),
        .o_expire (w_expire)
    );

    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_data_out    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_phase       <= 1'b0;
            r_fin         <= 1'b0;
            r_meta        <= '0;
            r_scan_halves <= '0;
            r_scan_cnt    <= '0;
            r_sync_cnt    <= '0;
            r_bit_idx     <= '0;
        end else begin
            r_data_out <= w_pulse;
            r_done     <= 1'b0;
            if (w_abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_phase <= 1'b0;
                r_fin   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_meta        <= meta;
                            r_scan_halves <= scan_halves;
                            r_busy        <= 1'b1;
                            r_phase       <= 1'b0;
                            r_fin         <= 1'b0;
                            r_sync_cnt    <= 2'd1;   // P0 goes out on this edge
                            r_state       <= ST_SYNC;
                        end
                    end
                    ST_SYNC: begin
                        if (w_expire) begin
                            if (r_sync_cnt == 2'(NUM_SYNC - 1)) begin
                                r_state <= ST_META_START;
                            end else begin
                                r_sync_cnt <= r_sync_cnt + 2'd1;
                            end
                        end
                    end
                    ST_META_START: begin
                        if (w_expire) begin
                            r_bit_idx <= 2'd0;
                            r_state   <= ST_BIT_A;
                        end
                    end
                    ST_BIT_A: begin
                        if (w_expire) begin
                            r_state <= ST_BIT_B;
                        end
                    end
                    ST_BIT_B: begin
                        if (w_expire) begin
                            // Index wraps back to 0 as the bit field completes.
                            r_bit_idx <= w_bit_next;
                            if (r_bit_idx == 2'(NUM_META_BITS - 1)) begin
                                r_state <= ST_SCAN_START;
                            end else begin
                                r_state <= ST_BIT_A;
                            end
                        end
                    end
                    ST_SCAN_START: begin
                        if (r_fin) begin
                            r_fin   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_expire) begin
                            r_phase    <= 1'b0;
                            r_scan_cnt <= 8'd0;
                            if (r_scan_halves == 8'd0) begin
                                r_fin <= 1'b1;
                            end else begin
                                r_state <= ST_SCAN;
                            end
                        end
                    end
                    ST_SCAN: begin
                        if (r_fin) begin
                            r_fin   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_expire) begin
                            r_phase    <= ~r_phase;
                            r_scan_cnt <= w_scan_next;
                            if (w_scan_next == r_scan_halves) begin
                                r_fin <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        // start is ignored here; frames begin from IDLE only.
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DATA_OUT  = r_data_out;
    assign busy      = r_busy;
    assign done      = r_done;
    assign phase     = r_phase;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_fsm_tx.sv
// -----------------------------------------------------------------------------
// tb_fsm_tx
// Directed frames against hand-derived pulse timetables for fsm_tx with
// CLKS_PER_TICK=4, SYNC_GAP=2, META_GAP=3, SHORT_T=1, LONG_T=3, SCAN_HALF=2.
// Cycle 0 of a frame is the cycle in which start is driven high.
// -----------------------------------------------------------------------------
module tb_fsm_tx;
    import fsm_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] meta;
    logic [7:0] scan_halves;
    logic       abort;
    logic       DATA_OUT;
    logic       busy;
    logic       done;
    logic       phase;
    logic [3:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    fsm_tx #(
        .CLKS_PER_TICK (4),
        .SYNC_GAP      (2),
        .META_GAP      (3),
        .SHORT_T       (1),
        .LONG_T        (3),
        .SCAN_HALF     (2)
    ) dut (
        .CLK_IN      (clk),
        .rst_n       (rst_n),
        .start       (start),
        .meta        (meta),
        .scan_halves (scan_halves),
        .abort       (abort),
        .DATA_OUT    (DATA_OUT),
        .busy        (busy),
        .done        (done),
        .phase       (phase),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic in_q(input int c);
        foreach (exp_q[i]) begin
            if (int'(exp_q[i]) == c) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Leaves the bench at #1 after a rising edge, ready for cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs one frame, checking DATA_OUT/busy/done/phase every cycle against
    // exp_q and the given windows. Event cycles of -1 are disabled.
    task automatic run_frame(input logic [3:0] m, input logic [7:0] sh,
                             input int ncyc, input int busy_last, input int done_cyc,
                             input int ph_lo, input int ph_hi, input int xstart_cyc,
                             input int abort_cyc, input int rst_cyc, input int restart_cyc);
        logic exp_busy;
        meta        = m;
        scan_halves = sh;
        start       = 1'b1;
        abort       = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            exp_busy = (c <= busy_last) || (restart_cyc >= 0 && c > restart_cyc);
            chk("data_out", c, 32'(DATA_OUT), 32'(in_q(c)));
            chk("busy", c, 32'(busy), 32'(exp_busy));
            chk("done", c, 32'(done), 32'(c == done_cyc));
            chk("phase", c, 32'(phase), 32'(c >= ph_lo && c <= ph_hi));
            if (c == done_cyc) chk("state_done", c, 32'(state_dbg), 32'(ST_DONE));
            start = 1'b0;
            abort = 1'b0;
            if (c == xstart_cyc) begin
                start       = 1'b1;
                meta        = 4'b0000;
                scan_halves = 8'd0;
            end
            if (c == abort_cyc) abort = 1'b1;
            if (c == restart_cyc) begin
                start       = 1'b1;
                meta        = m;
                scan_halves = sh;
            end
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("rst_data_out", c, 32'(DATA_OUT), 32'd0);
                chk("rst_busy", c, 32'(busy), 32'd0);
                chk("rst_state", c, 32'(state_dbg), 32'(ST_IDLE));
            end
            if (rst_cyc >= 0 && c == rst_cyc + 3) rst_n = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        meta        = 4'd0;
        scan_halves = 8'd0;
        #3;
        chk("reset_data_out", 0, 32'(DATA_OUT), 32'd0);
        chk("reset_busy", 0, 32'(busy), 32'd0);
        chk("reset_done", 0, 32'(done), 32'd0);
        chk("reset_phase", 0, 32'(phase), 32'd0);
        chk("reset_state", 0, 32'(state_dbg), 32'(ST_IDLE));

        // Full frame, meta=0101, two scan halves.
        do_reset();
        exp_q = '{16'd1, 16'd9, 16'd17, 16'd29, 16'd41, 16'd45, 16'd49, 16'd61,
                  16'd73, 16'd77, 16'd81, 16'd93, 16'd105, 16'd113, 16'd121};
        run_frame(4'b0101, 8'd2, 125, 121, 122, 113, 120, -1, -1, -1, -1);

        // Same frame with start/meta=0000 re-driven mid-frame: no effect.
        do_reset();
        run_frame(4'b0101, 8'd2, 124, 121, 122, 113, 120, 50, -1, -1, -1);

        // meta=1111, no scan halves; start in the DONE cycle is ignored.
        do_reset();
        exp_q = '{16'd1, 16'd9, 16'd17, 16'd29, 16'd41, 16'd45, 16'd57, 16'd61,
                  16'd73, 16'd77, 16'd89, 16'd93, 16'd105};
        run_frame(4'b1111, 8'd0, 112, 105, 106, 1, 0, 106, -1, -1, -1);

        // Abort in the cycle before pulse 61, then a fresh start at 70.
        do_reset();
        exp_q = '{16'd1, 16'd9, 16'd17, 16'd29, 16'd41, 16'd45, 16'd49, 16'd71, 16'd79};
        run_frame(4'b0101, 8'd2, 85, 60, -1, 1, 0, -1, 60, -1, 70);

        // Reset asserted mid-frame at cycle 30 for three cycles.
        do_reset();
        exp_q = '{16'd1, 16'd9, 16'd17, 16'd29};
        run_frame(4'b0101, 8'd2, 40, 30, -1, 1, 0, -1, -1, 30, -1);

        // abort together with start in IDLE: frame does not start.
        start = 1'b1;
        abort = 1'b1;
        meta  = 4'b0101;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            chk("idle_abort_data_out", c, 32'(DATA_OUT), 32'd0);
            chk("idle_abort_busy", c, 32'(busy), 32'd0);
            chk("idle_abort_state", c, 32'(state_dbg), 32'(ST_IDLE));
        end

        // abort alone in IDLE, then a plain start is still accepted.
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("idle_abort_only_state", 1, 32'(state_dbg), 32'(ST_IDLE));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("after_abort_p0", 1, 32'(DATA_OUT), 32'd1);
        chk("after_abort_busy", 1, 32'(busy), 32'd1);
        chk("after_abort_state", 1, 32'(state_dbg), 32'(ST_SYNC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
